// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and FSM state type for the round-robin 4:1 packet arbiter.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Pointer value out of reset: the scan starts at ptr+1, so requester 0 leads.
    localparam logic [SEL_W-1:0] PTR_RST = 2'd3;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin choice: first valid index scanning ptr+1 .. ptr+4 (mod 4).
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + k[SEL_W-1:0];
            if (req_valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 4:1 packet arbiter with a locked grant until the last beat transfers.
module rr_mux_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [1:0]               sel,
    output logic                     busy
);

    import rr_mux_arbiter_pkg::*;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             granted;
    logic             xfer_last;
    logic [WIDTH-1:0] word [NUM_REQ];

    rr_pick u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
        assign word[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Outputs depend only on registered state/sel plus same-cycle inputs.
    assign granted   = (state == GRANT);
    assign busy      = granted;
    assign out_data  = word[sel];
    assign out_valid = granted & req_valid[sel];
    assign out_last  = granted & req_last[sel];
    assign xfer_last = out_valid & out_ready & out_last;

    always_comb begin
        req_ready = '0;
        if (granted) begin
            req_ready[sel] = out_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= PTR_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        sel   <= pick_idx;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    // Grant stays locked until the end-of-packet beat is accepted.
                    if (xfer_last) begin
                        ptr   <= sel;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: behavioural round-robin model, per-cycle compare, directed scenarios and random traffic.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         req_valid = '0;
    logic [4*WIDTH-1:0] req_data = '0;
    logic [3:0]         req_last = '0;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready = 1'b0;
    logic [1:0]         sel;
    logic               busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(WIDTH), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a flag for "holding a grant", the granted index and the last winner.
    bit m_grant = 1'b0;
    int m_sel   = 0;
    int m_ptr   = 3;

    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grant <= 1'b0;
            m_sel   <= 0;
            m_ptr   <= 3;
        end else if (!m_grant) begin
            if (pick(req_valid, m_ptr) >= 0) begin
                m_sel   <= pick(req_valid, m_ptr);
                m_grant <= 1'b1;
            end
        end else if (req_valid[m_sel] && out_ready && req_last[m_sel]) begin
            m_ptr   <= m_sel;
            m_grant <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit prev_busy = 1'b0;
    int glog[$];
    int gcyc[$];

    always @(negedge clk) begin : cmp
        chk("busy", busy, m_grant);
        chk("sel", sel, m_sel);
        chk("out_valid", out_valid, m_grant ? req_valid[m_sel] : 1'b0);
        chk("req_ready", req_ready, m_grant ? (32'(out_ready) << m_sel) : 32'd0);
        chk("out_data", out_data, req_data[m_sel*WIDTH +: WIDTH]);
        if (m_grant || rst) chk("out_last", out_last, m_grant ? req_last[m_sel] : 1'b0);
        if (busy && !prev_busy) begin
            glog.push_back(sel);
            gcyc.push_back(cyc);
        end
        prev_busy <= busy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", sel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, req_data[WIDTH-1:0]);
        step();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int beats;
        req_data = $urandom;

        // All requesters valid through reset: first grant goes to 0.
        req_valid = 4'hF; req_last = 4'hF; out_ready = 1'b0;
        do_reset();
        step();
        #2;
        chk("first_grant_sel", sel, 0);
        chk("first_grant_busy", busy, 1);

        // Continuous single-beat packets from everyone.
        out_ready = 1'b1;
        do_reset();
        glog.delete(); gcyc.delete();
        repeat (10) begin
            req_data = $urandom;
            step();
        end
        chk("rr_grant_count_ok", glog.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) chk("rr_order", glog[i], i % 4);
            if (i + 1 < gcyc.size()) chk("rr_gap", gcyc[i+1] - gcyc[i], 2);
        end

        // Locked 3-beat packet from 2 while 1 waits, out_ready toggling.
        req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b0;
        do_reset();
        step();
        req_valid = 4'b0110;
        beats = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready   = (c % 2 == 0);
            req_last[2] = (beats == 2);
            req_data    = $urandom;
            #2;
            chk("lock_sel", sel, 2);
            chk("lock_busy", busy, 1);
            @(posedge clk);
            if (out_ready) beats++;
            #1;
        end
        #2;
        chk("lock_done_busy", busy, 0);
        step();
        #2;
        chk("lock_next_sel", sel, 1);
        chk("lock_next_busy", busy, 1);

        // Requester 3 stalls its valid for two cycles mid-packet.
        req_valid = 4'b1000; req_last = 4'b0000; out_ready = 1'b1;
        do_reset();
        step();
        step();
        req_valid = 4'b0000;
        repeat (2) begin
            #2;
            chk("stall_out_valid", out_valid, 0);
            chk("stall_sel", sel, 3);
            chk("stall_busy", busy, 1);
            step();
        end
        req_valid = 4'b1000;
        step();
        req_last = 4'b1000;
        #2;
        chk("stall_last_valid", out_valid, 1);
        chk("stall_last_last", out_last, 1);
        step();
        #2;
        chk("stall_done_busy", busy, 0);

        // Pointer now 3 with only requester 3 valid: the wrap still grants 3.
        step();
        #2;
        chk("wrap_sel", sel, 3);
        chk("wrap_busy", busy, 1);
        req_valid = 4'b0000;
        step();

        // Reset during beat 2 of a packet from requester 1.
        req_valid = 4'b0010; req_last = 4'b0000; out_ready = 1'b1;
        do_reset();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sel", sel, 0);
        step();
        step();
        req_valid = 4'b1010;
        rst = 1'b0;
        step();
        #2;
        chk("midrst_regrant_sel", sel, 1);
        chk("midrst_regrant_busy", busy, 1);
        step();

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom) & 4'($urandom);
            req_data  = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
